// File: rtl/atconv_pkg.sv
// Shared constants, FSM state encoding and small arithmetic helpers for the
// atrous-convolution engine.
package atconv_pkg;

  localparam int IMG_W  = 64;
  localparam int POOL_W = 32;
  localparam int DW     = 13;
  localparam int AW     = 12;
  localparam int ACC_W  = 20;
  localparam int DIL    = 2;

  localparam logic [DW-1:0] BIAS     = 13'h1FF4;
  localparam logic [3:0]    LAST_TAP = 4'd8;

  // The bias is folded into the accumulator seed at the same x16 scale as the taps.
  localparam logic signed [ACC_W-1:0] BIAS_X16 =
    $signed({{(ACC_W-DW){BIAS[DW-1]}}, BIAS}) <<< 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_L0_RD = 3'd1,
    S_L0_WR = 3'd2,
    S_L1_RD = 3'd3,
    S_L1_WR = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  // Coordinates only ever reach -2..65, so bit 7 flags below-range and bit 6 above.
  function automatic logic [5:0] clamp63(input logic signed [7:0] v);
    if (v[7]) begin
      return 6'd0;
    end else if (v[6]) begin
      return 6'd63;
    end else begin
      return v[5:0];
    end
  endfunction

  // Weighted contribution of one tap, x16 scale; taps are numbered row-major.
  function automatic logic signed [ACC_W-1:0] tap_term(input logic [3:0]    tap,
                                                       input logic [DW-1:0] px);
    logic signed [ACC_W-1:0] p;
    p = $signed({{(ACC_W-DW){1'b0}}, px});
    case (tap)
      4'd4:       return p <<< 4;
      4'd1, 4'd7: return -(p <<< 1);
      4'd3, 4'd5: return -(p <<< 2);
      default:    return -p;
    endcase
  endfunction

endpackage

// File: rtl/atconv_tap_addr.sv
// Maps an output pixel and tap index to the edge-replicated image address of
// that tap (dilation 2, 3x3 window).
module atconv_tap_addr
  import atconv_pkg::*;
(
  input  logic [5:0]    i_row,
  input  logic [5:0]    i_col,
  input  logic [3:0]    i_tap,
  output logic [AW-1:0] o_addr
);

  logic signed [7:0] w_dr;
  logic signed [7:0] w_dc;
  logic [5:0]        w_row;
  logic [5:0]        w_col;

  always_comb begin
    w_dr = 8'sd0;
    w_dc = 8'sd0;
    case (i_tap)
      4'd0, 4'd1, 4'd2: w_dr = -8'(DIL);
      4'd6, 4'd7, 4'd8: w_dr = 8'(DIL);
      default:          w_dr = 8'sd0;
    endcase
    case (i_tap)
      4'd0, 4'd3, 4'd6: w_dc = -8'(DIL);
      4'd2, 4'd5, 4'd8: w_dc = 8'(DIL);
      default:          w_dc = 8'sd0;
    endcase
    w_row  = clamp63($signed({2'b00, i_row}) + w_dr);
    w_col  = clamp63($signed({2'b00, i_col}) + w_dc);
    o_addr = {w_row, w_col};
  end

endmodule

// File: rtl/atconv.sv
// Atrous convolution engine: dilated 3x3 conv + bias + ReLU into bank 0, then
// 2x2 max-pool with round-up into bank 1.
module atconv
  import atconv_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          ready,
  output logic          busy,
  output logic [AW-1:0] iaddr,
  input  logic [DW-1:0] idata,
  output logic          cwr,
  output logic [AW-1:0] caddr_wr,
  output logic [DW-1:0] cdata_wr,
  output logic          crd,
  output logic [AW-1:0] caddr_rd,
  input  logic [DW-1:0] cdata_rd,
  output logic          csel
);

  // Handshake: ready is only looked at in IDLE; a high sample there starts a
  // run and busy stays high until the final pooled word has been written.
  // Memory reads return data by the next rising edge, so every request cycle
  // also consumes the data of that same request at its closing edge.

  state_e r_state;
  state_e w_next;

  logic [AW-1:0]           r_pix;
  logic [9:0]              r_pool;
  logic [3:0]              r_tap;
  logic [1:0]              r_sub;
  logic signed [ACC_W-1:0] r_acc;
  logic [DW-1:0]           r_max;

  logic [AW-1:0]           w_tap_addr;
  logic signed [ACC_W-1:0] w_acc_sh;
  logic [DW-1:0]           w_l0_res;
  logic [DW-1:0]           w_l1_res;

  atconv_tap_addr u_tap_addr (
    .i_row  (r_pix[11:6]),
    .i_col  (r_pix[5:0]),
    .i_tap  (r_tap),
    .o_addr (w_tap_addr)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pix  <= '0;
      r_pool <= '0;
      r_tap  <= '0;
      r_sub  <= '0;
      r_acc  <= '0;
      r_max  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_pix  <= '0;
          r_pool <= '0;
          r_tap  <= '0;
          r_sub  <= '0;
        end
        S_L0_RD: begin
          r_acc <= ((r_tap == 4'd0) ? BIAS_X16 : r_acc) + tap_term(r_tap, idata);
          r_tap <= (r_tap == LAST_TAP) ? 4'd0 : r_tap + 4'd1;
        end
        S_L0_WR: begin
          r_pix <= r_pix + 12'd1;
        end
        S_L1_RD: begin
          if ((r_sub == 2'd0) || (cdata_rd > r_max)) begin
            r_max <= cdata_rd;
          end
          r_sub <= r_sub + 2'd1;
        end
        S_L1_WR: begin
          r_pool <= r_pool + 10'd1;
        end
        default: begin
        end
      endcase
    end
  end

  // Floor by arithmetic shift, then ReLU and saturation to the 13-bit range.
  always_comb begin
    w_acc_sh = r_acc >>> 4;
    if (w_acc_sh[ACC_W-1]) begin
      w_l0_res = '0;
    end else if (|w_acc_sh[ACC_W-2:DW]) begin
      w_l0_res = 13'h1FFF;
    end else begin
      w_l0_res = w_acc_sh[DW-1:0];
    end
    w_l1_res = (r_max[3:0] == 4'd0) ? r_max : {r_max[12:4] + 9'd1, 4'b0000};
  end

  always_comb begin
    w_next   = r_state;
    busy     = 1'b0;
    iaddr    = '0;
    cwr      = 1'b0;
    caddr_wr = '0;
    cdata_wr = '0;
    crd      = 1'b0;
    caddr_rd = '0;
    csel     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ready) begin
          w_next = S_L0_RD;
        end
      end
      S_L0_RD: begin
        busy  = 1'b1;
        iaddr = w_tap_addr;
        if (r_tap == LAST_TAP) begin
          w_next = S_L0_WR;
        end
      end
      S_L0_WR: begin
        busy     = 1'b1;
        cwr      = 1'b1;
        caddr_wr = r_pix;
        cdata_wr = w_l0_res;
        w_next   = (r_pix == 12'hFFF) ? S_L1_RD : S_L0_RD;
      end
      S_L1_RD: begin
        // Window (2R+sub[1], 2C+sub[0]) of the 64-wide layer-0 map.
        busy     = 1'b1;
        crd      = 1'b1;
        caddr_rd = {r_pool[9:5], r_sub[1], r_pool[4:0], r_sub[0]};
        if (r_sub == 2'd3) begin
          w_next = S_L1_WR;
        end
      end
      S_L1_WR: begin
        busy     = 1'b1;
        cwr      = 1'b1;
        csel     = 1'b1;
        caddr_wr = {2'b00, r_pool};
        cdata_wr = w_l1_res;
        w_next   = (r_pool == 10'h3FF) ? S_DONE : S_L1_RD;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_atconv.sv
// Directed bench for atconv: composite image (corner and interior impulses,
// constant band, random patch), mid-run abort, then one full checked run.
module tb_atconv;

  logic        clk = 1'b0;
  logic        reset;
  logic        ready;
  logic        busy;
  logic [11:0] iaddr;
  logic [12:0] idata;
  logic        cwr;
  logic [11:0] caddr_wr;
  logic [12:0] cdata_wr;
  logic        crd;
  logic [11:0] caddr_rd;
  logic [12:0] cdata_rd;
  logic        csel;

  logic [12:0] img    [4096];
  logic [12:0] l0_mem [4096];
  logic [12:0] l1_mem [1024];
  int          e0     [4096];
  logic [12:0] exp_q[$];
  int          wt     [9] = '{-1, -2, -1, -4, 16, -4, -1, -2, -1};

  int   n_cmp = 0;
  int   n_mis = 0;
  int   n_wr = 0;
  int   n_wr0 = 0;
  int   n_wr1 = 0;
  int   n_wr_rst = 0;
  int   proto_err = 0;
  int   n_wr_base = 0;
  int   base0 = 0;
  int   base1 = 0;
  int   abort_wr = 0;
  logic mon_en = 1'b0;

  atconv dut (
    .clk      (clk),
    .reset    (reset),
    .ready    (ready),
    .busy     (busy),
    .iaddr    (iaddr),
    .idata    (idata),
    .cwr      (cwr),
    .caddr_wr (caddr_wr),
    .cdata_wr (cdata_wr),
    .crd      (crd),
    .caddr_rd (caddr_rd),
    .cdata_rd (cdata_rd),
    .csel     (csel)
  );

  always #5 clk = ~clk;

  assign idata    = img[iaddr];
  assign cdata_rd = l0_mem[caddr_rd];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Result RAM banks commit on the rising edge.
  always @(posedge clk) begin
    if (cwr) begin
      n_wr <= n_wr + 1;
      if (csel) begin
        l1_mem[caddr_wr[9:0]] <= cdata_wr;
        n_wr1 <= n_wr1 + 1;
      end else begin
        l0_mem[caddr_wr] <= cdata_wr;
        n_wr0 <= n_wr0 + 1;
      end
      if (!reset) n_wr_rst <= n_wr_rst + 1;
    end
  end

  // Scoreboard: every write of the checked run is popped against exp_q in order.
  always @(negedge clk) begin
    if (mon_en && reset && cwr) begin
      if (exp_q.size() == 0) begin
        check("wr_extra", exp_q.size(), 1);
      end else begin
        check("wr_sel_addr", {19'd0, csel, caddr_wr}, n_wr - n_wr_base);
        check("wr_data", cdata_wr, exp_q.pop_front());
      end
      if (n_wr - n_wr_base == 5119) check("busy_last_wr", busy, 1);
    end
    if ((cwr && crd) || (mon_en && crd && (n_wr - n_wr_base) < 4096))
      proto_err <= proto_err + 1;
  end

  task automatic build_model();
    for (int r = 0; r < 64; r++) begin
      for (int c = 0; c < 64; c++) begin
        int acc;
        acc = -192;
        for (int t = 0; t < 9; t++) begin
          int rr;
          int cc;
          rr = r + 2 * (t / 3) - 2;
          cc = c + 2 * (t % 3) - 2;
          if (rr < 0) rr = 0;
          if (rr > 63) rr = 63;
          if (cc < 0) cc = 0;
          if (cc > 63) cc = 63;
          acc += wt[t] * int'(img[rr * 64 + cc]);
        end
        if (acc < 0) e0[r * 64 + c] = 0;
        else if (acc / 16 > 8191) e0[r * 64 + c] = 8191;
        else e0[r * 64 + c] = acc / 16;
        exp_q.push_back(13'(e0[r * 64 + c]));
      end
    end
    for (int pr = 0; pr < 32; pr++) begin
      for (int pc = 0; pc < 32; pc++) begin
        int m;
        m = e0[(2 * pr) * 64 + 2 * pc];
        if (e0[(2 * pr) * 64 + 2 * pc + 1] > m) m = e0[(2 * pr) * 64 + 2 * pc + 1];
        if (e0[(2 * pr + 1) * 64 + 2 * pc] > m) m = e0[(2 * pr + 1) * 64 + 2 * pc];
        if (e0[(2 * pr + 1) * 64 + 2 * pc + 1] > m) m = e0[(2 * pr + 1) * 64 + 2 * pc + 1];
        exp_q.push_back(13'(((m + 15) / 16) * 16));
      end
    end
  endtask

  task automatic check_idle_outputs(input string phase);
    check({phase, "_busy"}, busy, 0);
    check({phase, "_cwr"}, cwr, 0);
    check({phase, "_crd"}, crd, 0);
    check({phase, "_csel"}, csel, 0);
    check({phase, "_iaddr"}, iaddr, 0);
    check({phase, "_caddr_wr"}, caddr_wr, 0);
    check({phase, "_caddr_rd"}, caddr_rd, 0);
    check({phase, "_cdata_wr"}, cdata_wr, 0);
  endtask

  initial begin
    reset = 1'b0;
    ready = 1'b0;

    for (int i = 0; i < 4096; i++) img[i] = 13'h0000;
    img[0]           = 13'h0100;
    img[10 * 64 + 10] = 13'h0100;
    for (int r = 20; r < 34; r++)
      for (int c = 0; c < 64; c++) img[r * 64 + c] = 13'h0010;
    for (int r = 40; r < 64; r++)
      for (int c = 32; c < 64; c++) img[r * 64 + c] = 13'($urandom_range(0, 8191));
    build_model();

    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b1;
    @(negedge clk);
    check("idle_no_ready_busy", busy, 0);

    // First run: probe early tap addresses, then abort mid-layer-0.
    ready = 1'b1;
    @(negedge clk);
    check("start_busy", busy, 1);
    check("tap0_iaddr", iaddr, 0);
    ready = 1'b0;
    repeat (2) @(negedge clk);
    check("tap2_iaddr", iaddr, 2);
    repeat (4) @(negedge clk);
    check("tap6_iaddr", iaddr, 128);
    repeat (1000) @(negedge clk);
    check("pre_abort_busy", busy, 1);
    reset = 1'b0;
    #1;
    check_idle_outputs("abort");
    abort_wr = n_wr;
    repeat (3) @(negedge clk);
    check("no_wr_in_reset", n_wr, abort_wr);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("post_abort_busy", busy, 0);
    check("no_wr_after_abort", n_wr, abort_wr);

    // Second run: full, checked word by word.
    n_wr_base = n_wr;
    base0     = n_wr0;
    base1     = n_wr1;
    mon_en    = 1'b1;
    ready     = 1'b1;
    @(negedge clk);
    check("run_busy", busy, 1);
    ready = 1'b0;
    for (int k = 0; k < 60000; k++) begin
      @(negedge clk);
      if (n_wr - n_wr_base >= 5120) break;
    end
    check("run_writes", n_wr - n_wr_base, 5120);
    check("busy_fall", busy, 0);
    check("l0_write_count", n_wr0 - base0, 4096);
    check("l1_write_count", n_wr1 - base1, 1024);
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_cwr", cwr, 0);
    mon_en = 1'b0;

    check("exp_q_left", exp_q.size(), 0);
    check("protocol", proto_err, 0);
    check("wr_during_reset", n_wr_rst, 0);

    check("l0_corner", l0_mem[0], 13'h0084);
    check("l1_corner", l1_mem[0], 13'h0090);
    check("l0_impulse", l0_mem[10 * 64 + 10], 13'h00F4);
    check("l0_impulse_nbr", l0_mem[10 * 64 + 12], 13'h0000);
    check("l1_impulse", l1_mem[5 * 32 + 5], 13'h0100);
    check("l0_flat", l0_mem[26 * 64 + 30], 13'h0000);
    check("l1_flat", l1_mem[13 * 32 + 15], 13'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
